muldiv_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit with HI/LO registers.
- Sits beside the single-cycle ALU in the execute stage and decodes R-type funct codes for mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- Uses a radix-2 iterative datapath: one bit per cycle, fixed latency.
- Asserts busy so the controller stalls the pipeline or PC until the result lands.

---
 rtl/muldiv_unit.sv | 235 +++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Radix-2 iterative multiply/divide unit with HI/LO registers.
//               Decodes mult/multu/div/divu/mfhi/mflo/mthi/mtlo funct codes.
//               Optional macro MULDIV_DIV0_TRAP_EN adds a div0 output and
//               short-circuits divide-by-zero.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rdata
`ifdef MULDIV_DIV0_TRAP_EN
    ,
    output logic             div0
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [5:0] c_f_mfhi  = 6'b010000;
    localparam logic [5:0] c_f_mthi  = 6'b010001;
    localparam logic [5:0] c_f_mflo  = 6'b010010;
    localparam logic [5:0] c_f_mtlo  = 6'b010011;
    localparam logic [5:0] c_f_mult  = 6'b011000;
    localparam logic [5:0] c_f_multu = 6'b011001;
    localparam logic [5:0] c_f_div   = 6'b011010;
    localparam logic [5:0] c_f_divu  = 6'b011011;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_mul  = 2'd1;
    localparam logic [1:0] c_st_div  = 2'd2;
    localparam logic [1:0] c_st_fix  = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_prod;
    logic [WIDTH-1:0]     r_opb;
    logic [WIDTH:0]       r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic                 r_qneg;
    logic                 r_rneg;
    logic                 r_is_div;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_done;

    logic                 w_is_mul;
    logic                 w_is_div;
    logic                 w_signed;
    logic                 w_sa;
    logic                 w_sb;
    logic [WIDTH-1:0]     w_absa;
    logic [WIDTH-1:0]     w_absb;
    logic [WIDTH:0]       w_add;
    logic [2*WIDTH-1:0]   w_prod_step;
    logic [WIDTH+1:0]     w_shift;
    logic [WIDTH+1:0]     w_diff;
    logic [WIDTH:0]       w_rem_step;
    logic [WIDTH-1:0]     w_quo_step;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;
    logic                 w_fix_wr;

    // ---------------- operand decode ----------------
    assign w_is_mul = (funct == c_f_mult) || (funct == c_f_multu);
    assign w_is_div = (funct == c_f_div)  || (funct == c_f_divu);
    assign w_signed = (funct == c_f_mult) || (funct == c_f_div);
    assign w_sa     = w_signed & srca[WIDTH-1];
    assign w_sb     = w_signed & srcb[WIDTH-1];
    assign w_absa   = w_sa ? -srca : srca;
    assign w_absb   = w_sb ? -srcb : srcb;

`ifdef MULDIV_DIV0_TRAP_EN
    logic r_trap;
    logic r_div0;
    logic w_trap;
    assign w_trap   = w_is_div && (srcb == '0);
    assign w_fix_wr = ~r_trap;
    assign div0     = r_div0;
`else
    assign w_fix_wr = 1'b1;
`endif

    // ---------------- iteration datapath ----------------
    // Multiply: upper half accumulates, multiplier bits shift out of the low half.
    assign w_add       = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                       + {1'b0, r_opb & {WIDTH{r_prod[0]}}};
    assign w_prod_step = {w_add, r_prod[WIDTH-1:1]};

    // Restoring divide: keep the trial difference only when it did not borrow.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_diff     = w_shift - {2'b00, r_opb};
    assign w_rem_step = w_diff[WIDTH+1] ? w_shift[WIDTH:0] : w_diff[WIDTH:0];
    assign w_quo_step = {r_quo[WIDTH-2:0], ~w_diff[WIDTH+1]};

    assign w_prod_fix = r_qneg ? -r_prod : r_prod;
    assign w_quo_fix  = r_qneg ? -r_quo  : r_quo;
    assign w_rem_fix  = r_rneg ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    if (w_is_mul) begin
                        w_next = c_st_mul;
                    end else if (w_is_div) begin
`ifdef MULDIV_DIV0_TRAP_EN
                        w_next = w_trap ? c_st_fix : c_st_div;
`else
                        w_next = c_st_div;
`endif
                    end
                end
            end
            c_st_mul, c_st_div: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_next = c_st_fix;
                end
            end
            c_st_fix: w_next = c_st_idle;
            default:  w_next = c_st_idle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (r_state != c_st_idle);
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_prod   <= '0;
            r_opb    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_is_div <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
`ifdef MULDIV_DIV0_TRAP_EN
            r_trap   <= 1'b0;
            r_div0   <= 1'b0;
`endif
        end else begin
            r_done <= (r_state == c_st_fix);
`ifdef MULDIV_DIV0_TRAP_EN
            r_div0 <= (r_state == c_st_fix) && r_trap;
`endif
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        if (funct == c_f_mthi) begin
                            r_hi <= srca;
                        end
                        if (funct == c_f_mtlo) begin
                            r_lo <= srca;
                        end
                        if (w_is_mul || w_is_div) begin
                            r_cnt    <= CNT_W'(WIDTH);
                            r_qneg   <= w_sa ^ w_sb;
                            r_rneg   <= w_sa;
                            r_is_div <= w_is_div;
                            r_prod   <= {{WIDTH{1'b0}}, w_absb};
                            r_opb    <= w_is_div ? w_absb : w_absa;
                            r_rem    <= '0;
                            r_quo    <= w_absa;
`ifdef MULDIV_DIV0_TRAP_EN
                            r_trap   <= w_trap;
`endif
                        end
                    end
                end
                c_st_mul: begin
                    r_prod <= w_prod_step;
                    r_cnt  <= r_cnt - CNT_W'(1);
                end
                c_st_div: begin
                    r_rem <= w_rem_step;
                    r_quo <= w_quo_step;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                c_st_fix: begin
                    if (w_fix_wr) begin
                        if (r_is_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi    = r_hi;
    assign lo    = r_lo;
    assign done  = r_done;
    // Read port follows the current funct even while a long op is running.
    assign rdata = (funct == c_f_mfhi) ? r_hi :
                   (funct == c_f_mflo) ? r_lo : '0;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit (WIDTH=32), directed and
//               random operations against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int W = 32;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [5:0]   funct;
    logic [W-1:0] srca;
    logic [W-1:0] srcb;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] rdata;
`ifdef MULDIV_DIV0_TRAP_EN
    logic         div0;
`endif

    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] m_hi  = '0;
    logic [W-1:0] m_lo  = '0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .funct (funct),
        .srca  (srca),
        .srcb  (srcb),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .rdata (rdata)
`ifdef MULDIV_DIV0_TRAP_EN
        ,
        .div0  (div0)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain signed/unsigned arithmetic on 64-bit values.
    function automatic void model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] eh, output logic [W-1:0] el);
        logic signed [63:0] sa, sb, sp, sq, sr;
        logic [63:0]        ua, ub, up;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        eh = '0;
        el = '0;
        case (f)
            F_MULT:  begin sp = sa * sb; eh = sp[63:32]; el = sp[31:0]; end
            F_MULTU: begin up = ua * ub; eh = up[63:32]; el = up[31:0]; end
            F_DIVU: begin
                if (b == '0) begin eh = a; el = '1; end
                else begin eh = a % b; el = a / b; end
            end
            F_DIV: begin
                if (b == '0) begin eh = a; el = a[31] ? 32'd1 : 32'hFFFFFFFF; end
                else begin sq = sa / sb; sr = sa % sb; eh = sr[31:0]; el = sq[31:0]; end
            end
            default: ;
        endcase
    endfunction

    task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        funct = f;
        srca  = a;
        srcb  = b;
        step();
        start = 1'b0;
        funct = 6'd0;
        srca  = $urandom;
        srcb  = $urandom;
    endtask

    task automatic read_check(input string tag);
        funct = F_MFHI;
        #1;
        check({tag, " mfhi"}, rdata, m_hi);
        funct = F_MFLO;
        #1;
        check({tag, " mflo"}, rdata, m_lo);
        funct = 6'd0;
    endtask

    task automatic move(input string tag, input logic [5:0] f, input logic [W-1:0] a);
        issue(f, a, '0);
        if (f == F_MTHI) m_hi = a;
        else             m_lo = a;
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " hi"}, hi, m_hi);
        check({tag, " lo"}, lo, m_lo);
    endtask

    // Starts a long op at the current cycle; inj>0 pulses an mtlo in that cycle.
    task automatic run_long(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                            input logic [W-1:0] b, input int inj);
        logic [W-1:0] eh, el;
        bit           busy_ok, early;
        busy_ok = 1'b1;
        early   = 1'b0;
        model(f, a, b, eh, el);
`ifdef MULDIV_DIV0_TRAP_EN
        if ((f == F_DIV || f == F_DIVU) && b == '0) begin
            issue(f, a, b);
            check({tag, " trap busy"}, busy, 1);
            check({tag, " trap early done"}, done, 0);
            step();
            check({tag, " trap done"}, done, 1);
            check({tag, " trap div0"}, div0, 1);
            check({tag, " trap busy end"}, busy, 0);
            check({tag, " trap hi"}, hi, m_hi);
            check({tag, " trap lo"}, lo, m_lo);
            return;
        end
`endif
        issue(f, a, b);
        for (int cyc = 1; cyc <= W + 1; cyc++) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done !== 1'b0) early = 1'b1;
            if (cyc == 10) read_check({tag, " mid-op"});
            if (cyc == inj) begin
                start = 1'b1;
                funct = F_MTLO;
                srca  = 32'hDEADBEEF;
            end
            step();
            start = 1'b0;
            funct = 6'd0;
        end
        check({tag, " busy window"}, busy_ok, 1);
        check({tag, " early done"}, early, 0);
        check({tag, " done"}, done, 1);
        check({tag, " busy end"}, busy, 0);
        check({tag, " hi"}, hi, eh);
        check({tag, " lo"}, lo, el);
        m_hi = eh;
        m_lo = el;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h00000000;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h00000001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        start = 1'b0;
        funct = 6'd0;
        srca  = '0;
        srcb  = '0;
        step();
        step();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        reset = 1'b0;

        run_long("mult -3*5", F_MULT, 32'hFFFFFFFD, 32'd5, 0);
        check("mult lo const", lo, 32'hFFFFFFF1);
        run_long("multu", F_MULTU, 32'hFFFFFFFF, 32'd2, 0);
        read_check("after multu");
        run_long("div -7/2", F_DIV, 32'hFFFFFFF9, 32'd2, 0);
        check("div hi const", hi, 32'hFFFFFFFF);
        run_long("div minneg/-1", F_DIV, 32'h80000000, 32'hFFFFFFFF, 0);

        move("mthi", F_MTHI, 32'h12345678);
        move("mtlo", F_MTLO, 32'h9ABCDEF0);
        read_check("after moves");

        issue(6'b100000, 32'h5, 32'h5);
        check("ignored funct busy", busy, 0);
        check("ignored funct hi", hi, m_hi);
        check("ignored funct lo", lo, m_lo);

        run_long("divu 100/7 mtlo@5", F_DIVU, 32'd100, 32'd7, 5);
        check("divu lo const", lo, 32'h0000000E);

        // Reset asserted in cycle 10 of a multiply.
        issue(F_MULT, 32'd3, 32'd4);
        for (int cyc = 1; cyc < 10; cyc++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort hi", hi, 0);
        check("abort lo", lo, 0);
        step();
        check("abort done c12", done, 0);
        run_long("divu after abort", F_DIVU, 32'd1000, 32'd33, 0);

        run_long("divu 7/0", F_DIVU, 32'd7, 32'd0, 0);
        run_long("div -16/0", F_DIV, 32'hFFFFFFF0, 32'd0, 0);

        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] a, b;
            a = pick();
            b = pick();
            case ($urandom_range(0, 7))
                0: run_long("rnd mult", F_MULT, a, b, 0);
                1: run_long("rnd multu", F_MULTU, a, b, 0);
                2: run_long("rnd div", F_DIV, a, b, 0);
                3: run_long("rnd divu", F_DIVU, a, b, 0);
                4: move("rnd mthi", F_MTHI, a);
                5: move("rnd mtlo", F_MTLO, a);
                6: read_check("rnd read");
                default: begin
                    issue(6'b100001, a, b);
                    check("rnd ignored hi", hi, m_hi);
                    check("rnd ignored lo", lo, m_lo);
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
